// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (port 1 wins on collision), NREAD
// combinational read ports, optional zero register, optional write bypass and a scrub engine.
module regfile_mp #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int NREAD    = 2,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clock,
  input  logic                   clear,
  input  logic                   write1,
  input  logic [AW-1:0]          writeIndex1,
  input  logic [WIDTH-1:0]       writeData1,
  input  logic                   write2,
  input  logic [AW-1:0]          writeIndex2,
  input  logic [WIDTH-1:0]       writeData2,
  input  logic [NREAD*AW-1:0]    readIndex,
  output logic [NREAD*WIDTH-1:0] readValue,
  input  logic                   scrubStart,
  output logic                   scrubBusy,
  output logic                   scrubDone,
  output logic                   writeCollision
);

  typedef enum logic {IDLE = 1'b0, SCRUB = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    sc_q, sc_d;
  logic             done_q, done_d;
  logic             coll_q, coll_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  logic busy;
  logic same_idx;
  logic we1, we2;

  assign busy     = (state_q == SCRUB);
  assign same_idx = (writeIndex1 == writeIndex2);

  // External writes are dropped while scrubbing; entry 0 is read-only with ZERO_REG.
  assign we1 = write1 && !busy && !((ZERO_REG != 0) && (writeIndex1 == '0));
  assign we2 = write2 && !busy && !(write1 && same_idx)
               && !((ZERO_REG != 0) && (writeIndex2 == '0));

  always_comb begin
    mem_d = mem_q;
    if (we2) mem_d[writeIndex2] = writeData2;
    if (we1) mem_d[writeIndex1] = writeData1;
    if (busy) mem_d[sc_q] = '0;
  end

  always_comb begin
    state_d = state_q;
    sc_d    = sc_q;
    done_d  = 1'b0;
    coll_d  = write1 && write2 && same_idx && !busy;
    case (state_q)
      IDLE: begin
        if (scrubStart) begin
          state_d = SCRUB;
          sc_d    = '0;
        end
      end
      SCRUB: begin
        if (sc_q == AW'(DEPTH - 1)) begin
          state_d = IDLE;
          sc_d    = '0;
          done_d  = 1'b1;
        end else begin
          sc_d = sc_q + AW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state_q <= IDLE;
      sc_q    <= '0;
      done_q  <= 1'b0;
      coll_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sc_q    <= sc_d;
      done_q  <= done_d;
      coll_q  <= coll_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end

  assign scrubBusy      = busy;
  assign scrubDone      = done_q;
  assign writeCollision = coll_q;

  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0]    idx;
    logic [WIDTH-1:0] val;

    assign idx = readIndex[k*AW +: AW];

    // Port 1 is applied last so it takes precedence over port 2 on a shared index.
    always_comb begin
      val = mem_q[idx];
      if ((BYPASS != 0) && !busy) begin
        if (write2 && (writeIndex2 == idx)) val = writeData2;
        if (write1 && (writeIndex1 == idx)) val = writeData1;
      end
      if ((ZERO_REG != 0) && (idx == '0)) val = '0;
    end

    assign readValue[k*WIDTH +: WIDTH] = val;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port register file: the next generation of the team's 32x32 dual-write register file. It generalises width, depth and read-port count, and adds several behaviours:
- optional hard-wired zero register;
- optional write-to-read bypass;
- a registered write-collision flag;
- a sequential scrub engine that zeroes the array one entry per cycle.

It sits beside the datapath as the architectural register store, with two writeback ports and NREAD operand read ports.

## Interface
Parameters:
- WIDTH, 32, data bits per entry
- DEPTH, 32, number of entries; power of two, >= 2; AW = clog2(DEPTH)
- NREAD, 2, number of independent read ports, >= 1
- ZERO_REG, 0, 1 = entry 0 always reads 0 and ignores writes
- BYPASS, 1, 1 = a same-cycle write to the read index is visible on readValue

Ports (clock and reset first):
- clock  in  1  single clock; all state changes on the rising edge
- clear  in  1  reset; synchronous, active-high
- write1  in  1  write enable, port 1
- writeIndex1  in  AW  write address, port 1
- writeData1  in  WIDTH  write data, port 1
- write2  in  1  write enable, port 2
- writeIndex2  in  AW  write address, port 2
- writeData2  in  WIDTH  write data, port 2
- readIndex  in  NREAD*AW  packed read addresses; port k is at bits [k*AW +: AW]
- readValue  out  NREAD*WIDTH  packed read data; port k is at bits [k*WIDTH +: WIDTH]; combinational
- scrubStart  in  1  request a full-array scrub
- scrubBusy  out  1  scrub in progress; external writes are dropped
- scrubDone  out  1  one-cycle pulse after the last entry is scrubbed
- writeCollision  out  1  registered; 1 for one cycle after an edge where both ports wrote the same index

## Operation
Writes:
- Applied at the rising edge.
- If write1 && write2 && writeIndex1 == writeIndex2, only writeData1 is stored (port 1 wins), and writeCollision = 1 on the following cycle.
- Otherwise, each enabled port writes its own index independently.

Zero register: with ZERO_REG = 1, writes to index 0 are discarded and every read of index 0 returns 0 (including under bypass).

Reads:
- Combinational from the array, per port.
- With BYPASS = 1 and scrubBusy = 0, if readIndex[k] matches an enabled write index in the same cycle, readValue[k] returns that write's data. Port 1 takes precedence when both ports match.
- With BYPASS = 0, the new value appears on the read port the cycle after the edge.

Scrub FSM (states IDLE, SCRUB; scrub counter sc of width AW):
- IDLE, scrubStart = 1: writes on this edge are still accepted; next state is SCRUB with sc = 0.
- SCRUB: each edge writes entry sc = 0 and increments sc. External write enables are ignored, bypass is disabled, and writeCollision stays 0.
- SCRUB, sc == DEPTH-1: after this final zeroing edge, the next state is IDLE and scrubDone = 1 for exactly one cycle.
- scrubStart is ignored while in SCRUB.
- Reads during a scrub return current array contents: already-scrubbed entries read 0, the rest keep their old values.

Clear:
- At a rising edge with clear = 1, all entries are set to 0, state = IDLE, sc = 0, and scrubDone = scrubBusy = writeCollision = 0.
- Clear has priority over writes, scrub and scrubStart, including when asserted mid-scrub; the scrub is abandoned and does not pulse scrubDone.

## Timing
- Reset values: every entry 0, readValue = 0 for all ports, scrubBusy 0, scrubDone 0, writeCollision 0.
- Write latency: 0 cycles to readValue with BYPASS = 1; 1 edge with BYPASS = 0.
- scrubBusy is registered: it rises on the edge that samples scrubStart and stays high for exactly DEPTH cycles.
- scrubDone is asserted in the first cycle after scrubBusy falls.
- Back-to-back scrubs: scrubStart held high returns the FSM to SCRUB on the edge after the scrubDone pulse (that edge samples IDLE). This leaves one IDLE cycle, in which writes are accepted, between scrubs.
- writeCollision: one-cycle registered pulse per colliding edge; it stays high on consecutive colliding edges.

## Test plan
- Clear, then write1 idx0 = 243 and write2 idx1 = 71 in one edge; read ports 0/1 = idx0/idx1 -> 243 / 71; writeCollision = 0.
- write1 idx2 = 741 and write2 idx2 = 12 in one edge -> idx2 reads 741; writeCollision = 1 for exactly one cycle.
- BYPASS = 1: write1 idx5 = 0xDEAD with readIndex = 5 in the same cycle -> readValue = 0xDEAD before the edge. BYPASS = 0: old value before the edge, 0xDEAD after.
- ZERO_REG = 1: write1 idx0 = 99 -> idx0 reads 0, both with bypass and after the edge.
- Fill all entries with nonzero data, pulse scrubStart (DEPTH = 32):
  - scrubBusy high for 32 cycles;
  - writes during the scrub are dropped;
  - idx31 keeps its old value until the final edge;
  - scrubDone pulses once, then all entries read 0.
- Start a scrub and assert clear at sc = 10 -> all entries 0 on that edge, scrubBusy 0, and no scrubDone pulse ever follows.
